mem_stage_access_ctrl: RTL and testbench
========================================

// Module: mem_stage_access_ctrl
// PURPOSE
//   MEM-stage consumer of the EX/MEM pipeline register outputs. Drives a req/ack
//   data-memory bus for loads/stores and stalls the pipeline until ack or timeout.
//   Registers the MEM/WB fields for the write-back stage.
//   Passes non-memory instructions through with 1-cycle latency.
// PARAMETERS
//   DATA_W   32  width of address, store data, load data, ALU result, PC+4
//   TIMEOUT  16  cycles in ACCESS without ack before a bus error is declared (>=2)
// PORTS
//   clk           in   1       clock, rising edge
//   reset         in   1       asynchronous, active-low reset
//   i_ALU_out     in   DATA_W  EX/MEM ALU result; memory address for loads/stores
//   i_Store_Data  in   DATA_W  EX/MEM store data
//   i_rd          in   5       EX/MEM destination register
//   i_PC_plus_4   in   DATA_W  EX/MEM PC+4
//   i_RegWrite    in   1       EX/MEM register write enable
//   i_MemWrite    in   1       EX/MEM store request
//   i_MemRead     in   1       EX/MEM load request
//   i_WDSel       in   2       EX/MEM write-back data select
//   o_mem_req     out  1       bus request (registered)
//   o_mem_we      out  1       1=write, 0=read; valid while o_mem_req=1
//   o_mem_addr    out  DATA_W  bus address; valid while o_mem_req=1
//   o_mem_wdata   out  DATA_W  bus write data; valid while o_mem_req=1
//   i_mem_ack     in   1       bus completion, sampled only in ACCESS
//   i_mem_rdata   in   DATA_W  read data, valid with i_mem_ack on reads
//   o_stall       out  1       freeze EX/MEM and earlier stages (combinational)
//   o_ALU_out, o_Mem_data, o_PC_plus_4  out DATA_W  MEM/WB data fields
//   o_rd          out  5       MEM/WB destination register
//   o_RegWrite    out  1       MEM/WB register write enable
//   o_WDSel       out  2       MEM/WB write-back select
//   o_bus_err     out  1       one-cycle pulse on timeout
// BEHAVIOUR
//   Reset (reset=0): state=IDLE, timeout counter=0, every registered output=0.
//     Takes effect immediately, including mid-access (req drops at once).
//   acc = i_MemRead | i_MemWrite. If both are set, write wins (we=1).
//   States:
//     IDLE, acc=0: MEM/WB regs load the i_* fields at the edge; o_Mem_data<=0; stall=0.
//     IDLE, acc=1: stall=1. MEM/WB loads a bubble (RegWrite=0, rd=0).
//       At the edge: latch addr/wdata/we, set req=1, counter=0, go to ACCESS.
//     ACCESS: stall=1; req/addr/wdata/we are held stable; bubble loaded each edge.
//       On ack: capture rdata (0 for writes), req<=0, go to DONE.
//       No ack: counter++. When counter reaches TIMEOUT-1 without ack:
//         req<=0, err flag set, go to DONE.
//       Ack on the final timeout cycle counts as success.
//     DONE: stall=0. At the edge MEM/WB loads the i_* fields plus captured data.
//       If err: o_RegWrite<=0, o_Mem_data<=0, o_bus_err<=1 for exactly one cycle.
//       Next state is IDLE.
//   i_* must stay stable while o_stall=1; pipeline control guarantees this.
//   i_mem_ack outside ACCESS is ignored.
//   Latency: non-memory op = 1 edge. Access with ack in ACCESS cycle k:
//     o_stall high for k+1 cycles; MEM/WB valid k+2 edges after the op enters.
//   Back-to-back accesses: min 3 cycles each (IDLE->ACCESS->DONE).
//     No IDLE bubble is inserted beyond that.
//   Counter width: $clog2(TIMEOUT)+1; it never wraps.
// TESTING
//   1 ALU op: ALU_out=0x10, rd=5, RegWrite=1 -> next edge o_ALU_out=0x10,
//     o_rd=5, o_RegWrite=1; o_stall=0 throughout.
//   2 Load at 0x100, ack in 3rd ACCESS cycle with rdata=0xDEADBEEF
//     -> req high 3 cycles, we=0; stall high 4 cycles; bubbles meanwhile;
//     then o_Mem_data=0xDEADBEEF, o_RegWrite=1.
//   3 Store 0x12345678 to 0x200, ack in 1st cycle -> we=1, wdata correct;
//     stall high 2 cycles; o_RegWrite follows i_RegWrite=0.
//   4 Load with no ack, TIMEOUT=16 -> req high 16 cycles then drops;
//     o_bus_err pulses 1 cycle; o_RegWrite=0, o_Mem_data=0.
//   5 reset=0 asserted in the 2nd ACCESS cycle -> req/outputs 0 immediately;
//     after release, IDLE; stall follows acc.
//   6 Two back-to-back loads, ack at cycle 16 on the 1st and cycle 1 on the 2nd
//     -> both succeed with no o_bus_err.
//     Also: ack pulses while IDLE are ignored.

Source files
------------

// File: rtl/mem_stage_access_ctrl.sv
// mem_stage_access_ctrl
//   MEM-stage controller sitting on the EX/MEM pipeline register. Loads and
//   stores are issued on a registered req/ack data-memory bus while the
//   pipeline is stalled. The stall ends on ack, or after TIMEOUT cycles
//   without ack, which is reported as a bus error. Non-memory instructions
//   pass to the MEM/WB register with a single edge of latency.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   i_ALU_out .. i_WDSel        EX/MEM fields (ALU result doubles as address)
//   o_mem_req/we/addr/wdata     data-memory bus request side (registered)
//   i_mem_ack, i_mem_rdata      data-memory bus response side
//   o_stall                     freeze EX/MEM and earlier stages (comb)
//   o_ALU_out .. o_WDSel        MEM/WB fields
//   o_bus_err                   one-cycle pulse after a timed-out access
module mem_stage_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_ALU_out,
  input  logic [DATA_W-1:0] i_Store_Data,
  input  logic [4:0]        i_rd,
  input  logic [DATA_W-1:0] i_PC_plus_4,
  input  logic              i_RegWrite,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  input  logic [1:0]        i_WDSel,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_ALU_out,
  output logic [DATA_W-1:0] o_Mem_data,
  output logic [DATA_W-1:0] o_PC_plus_4,
  output logic [4:0]        o_rd,
  output logic              o_RegWrite,
  output logic [1:0]        o_WDSel,
  output logic              o_bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_acc;
  logic              w_stall;
  logic              w_ack;
  logic              w_timeout;
  logic              w_load;    // MEM/WB takes the EX/MEM fields this edge
  logic              w_bubble;  // MEM/WB takes an empty slot this edge

  assign w_acc   = i_MemRead | i_MemWrite;
  assign o_stall = w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    w_load    = 1'b0;
    w_bubble  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          w_next   = S_ACCESS;
        end else begin
          w_load = 1'b1;
        end
      end
      S_ACCESS: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        // Ack has priority, so an ack on the last allowed cycle still succeeds.
        if (i_mem_ack) begin
          w_ack  = 1'b1;
          w_next = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        w_load = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Bus side: request registers, timeout counter, captured response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_acc) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_MemWrite;
        o_mem_addr  <= i_ALU_out;
        o_mem_wdata <= i_Store_Data;
        r_cnt       <= '0;
        r_rdata     <= '0;
        r_err       <= 1'b0;
      end else if (r_state == S_ACCESS) begin
        if (w_ack) begin
          o_mem_req <= 1'b0;
          r_rdata   <= o_mem_we ? '0 : i_mem_rdata;
        end else if (w_timeout) begin
          o_mem_req <= 1'b0;
          r_err     <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_ALU_out   <= '0;
      o_Mem_data  <= '0;
      o_PC_plus_4 <= '0;
      o_rd        <= '0;
      o_RegWrite  <= 1'b0;
      o_WDSel     <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      o_bus_err <= 1'b0;
      if (w_load) begin
        o_ALU_out   <= i_ALU_out;
        o_PC_plus_4 <= i_PC_plus_4;
        o_rd        <= i_rd;
        o_WDSel     <= i_WDSel;
        if (r_state == S_DONE) begin
          // A timed-out access must not write back anything.
          o_RegWrite <= i_RegWrite & ~r_err;
          o_Mem_data <= r_err ? '0 : r_rdata;
          o_bus_err  <= r_err;
        end else begin
          o_RegWrite <= i_RegWrite;
          o_Mem_data <= '0;
        end
      end else if (w_bubble) begin
        o_ALU_out   <= '0;
        o_Mem_data  <= '0;
        o_PC_plus_4 <= '0;
        o_rd        <= '0;
        o_RegWrite  <= 1'b0;
        o_WDSel     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
module tb_mem_stage_access_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] i_ALU_out;
  logic [DATA_W-1:0] i_Store_Data;
  logic [4:0]        i_rd;
  logic [DATA_W-1:0] i_PC_plus_4;
  logic              i_RegWrite;
  logic              i_MemWrite;
  logic              i_MemRead;
  logic [1:0]        i_WDSel;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [DATA_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_stall;
  logic [DATA_W-1:0] o_ALU_out;
  logic [DATA_W-1:0] o_Mem_data;
  logic [DATA_W-1:0] o_PC_plus_4;
  logic [4:0]        o_rd;
  logic              o_RegWrite;
  logic [1:0]        o_WDSel;
  logic              o_bus_err;

  int unsigned vectors;
  int unsigned miscompares;

  mem_stage_access_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_ALU_out   (i_ALU_out),
    .i_Store_Data(i_Store_Data),
    .i_rd        (i_rd),
    .i_PC_plus_4 (i_PC_plus_4),
    .i_RegWrite  (i_RegWrite),
    .i_MemWrite  (i_MemWrite),
    .i_MemRead   (i_MemRead),
    .i_WDSel     (i_WDSel),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_stall     (o_stall),
    .o_ALU_out   (o_ALU_out),
    .o_Mem_data  (o_Mem_data),
    .o_PC_plus_4 (o_PC_plus_4),
    .o_rd        (o_rd),
    .o_RegWrite  (o_RegWrite),
    .o_WDSel     (o_WDSel),
    .o_bus_err   (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction through the MEM stage. k = ACCESS cycle carrying the ack
  // (1..TIMEOUT), 0 = never acked. Expected outcome is derived from the
  // transaction rules: k ACCESS cycles (TIMEOUT if no ack), then one DONE
  // cycle, then the write-back fields appear.
  task automatic do_op(input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] pc4, input logic [4:0] rd,
                       input logic rw, input logic mw, input logic mr,
                       input logic [1:0] wds, input int unsigned k);
    logic        acc;
    logic        err;
    logic [31:0] rdata;
    int unsigned n;
    @(negedge clk);
    i_ALU_out    = alu;
    i_Store_Data = sd;
    i_PC_plus_4  = pc4;
    i_rd         = rd;
    i_RegWrite   = rw;
    i_MemWrite   = mw;
    i_MemRead    = mr;
    i_WDSel      = wds;
    // Stray ack while IDLE must have no effect.
    i_mem_ack    = 1'($urandom_range(0, 1));
    i_mem_rdata  = $urandom;
    acc = mw | mr;
    #1;
    check("stall_idle", o_stall, acc);
    check("req_idle", o_mem_req, 1'b0);
    @(posedge clk);
    #1;
    i_mem_ack = 1'b0;
    check("bus_err_quiet", o_bus_err, 1'b0);
    if (!acc) begin
      check("alu_pass", o_ALU_out, alu);
      check("rd_pass", o_rd, rd);
      check("pc4_pass", o_PC_plus_4, pc4);
      check("regwrite_pass", o_RegWrite, rw);
      check("wdsel_pass", o_WDSel, wds);
      check("memdata_pass", o_Mem_data, 32'h0);
      return;
    end
    check("req_issue", o_mem_req, 1'b1);
    check("we_issue", o_mem_we, mw);
    check("addr_issue", o_mem_addr, alu);
    check("wdata_issue", o_mem_wdata, sd);
    check("bubble_regwrite", o_RegWrite, 1'b0);
    check("bubble_rd", o_rd, 5'd0);
    n     = (k == 0) ? TIMEOUT : k;
    err   = (k == 0);
    rdata = $urandom;
    for (int unsigned c = 1; c <= n; c++) begin
      @(negedge clk);
      check("stall_access", o_stall, 1'b1);
      check("req_held", o_mem_req, 1'b1);
      check("addr_held", o_mem_addr, alu);
      check("bubble_access", o_RegWrite, 1'b0);
      if (c == k) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = rdata;
      end
      @(posedge clk);
      #1;
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
    end
    check("req_dropped", o_mem_req, 1'b0);
    check("stall_done", o_stall, 1'b0);
    check("bus_err_early", o_bus_err, 1'b0);
    i_mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    i_mem_ack = 1'b0;
    check("wb_alu", o_ALU_out, alu);
    check("wb_rd", o_rd, rd);
    check("wb_pc4", o_PC_plus_4, pc4);
    check("wb_wdsel", o_WDSel, wds);
    check("wb_regwrite", o_RegWrite, rw & ~err);
    check("wb_memdata", o_Mem_data, (err || mw) ? 32'h0 : rdata);
    check("wb_bus_err", o_bus_err, err);
  endtask

  initial begin
    int unsigned kind;
    int unsigned k;
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    i_ALU_out    = '0;
    i_Store_Data = '0;
    i_rd         = '0;
    i_PC_plus_4  = '0;
    i_RegWrite   = 1'b0;
    i_MemWrite   = 1'b0;
    i_MemRead    = 1'b0;
    i_WDSel      = '0;
    i_mem_ack    = 1'b0;
    i_mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", o_mem_req, 1'b0);
    check("rst_stall", o_stall, 1'b0);
    check("rst_alu", o_ALU_out, 32'h0);
    check("rst_regwrite", o_RegWrite, 1'b0);
    check("rst_bus_err", o_bus_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // ALU op passes through in one edge.
    do_op(32'h10, 32'h0, 32'h4, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    // Load at 0x100, ack in 3rd ACCESS cycle.
    do_op(32'h100, 32'h0, 32'h8, 5'd7, 1'b1, 1'b0, 1'b1, 2'd1, 3);
    // Store, ack in 1st cycle.
    do_op(32'h200, 32'h12345678, 32'hC, 5'd0, 1'b0, 1'b1, 1'b0, 2'd2, 1);
    // Load with no ack: timeout.
    do_op(32'h300, 32'h0, 32'h10, 5'd9, 1'b1, 1'b0, 1'b1, 2'd1, 0);
    // Read and write both set: write wins.
    do_op(32'h400, 32'hCAFEF00D, 32'h14, 5'd3, 1'b1, 1'b1, 1'b1, 2'd1, 2);
    // Back-to-back loads, ack on the last allowed cycle then on the first.
    do_op(32'h500, 32'h0, 32'h18, 5'd11, 1'b1, 1'b0, 1'b1, 2'd1, TIMEOUT);
    do_op(32'h504, 32'h0, 32'h1C, 5'd12, 1'b1, 1'b0, 1'b1, 2'd1, 1);

    // Reset in the 2nd ACCESS cycle.
    @(negedge clk);
    i_ALU_out  = 32'h600;
    i_rd       = 5'd13;
    i_RegWrite = 1'b1;
    i_MemRead  = 1'b1;
    i_MemWrite = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_req", o_mem_req, 1'b0);
    check("midrst_addr", o_mem_addr, 32'h0);
    check("midrst_alu", o_ALU_out, 32'h0);
    check("midrst_stall", o_stall, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("postrst_stall_acc", o_stall, 1'b1);
    i_MemRead = 1'b0;
    #1;
    check("postrst_stall_noacc", o_stall, 1'b0);
    @(posedge clk);
    #1;
    check("postrst_alu", o_ALU_out, 32'h600);
    check("postrst_rd", o_rd, 5'd13);
    check("postrst_req", o_mem_req, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      k    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      do_op($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
            (kind >= 6) ? 1'b1 : 1'b0, (kind >= 3 && kind != 7) ? 1'b1 : 1'b0,
            2'($urandom), k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
